// File: rtl/log2_sum_acc.sv
// Accumulates clamped Q4.12 pow2 results of one softmax vector, then produces the
// Mitchell-approximated log2 of the sum (signed Q4.12) for the next reduction stage.
module log2_sum_acc #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = $clog2(MAX_LEN) + 1,
    parameter int ACC_W   = 13 + $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             last_in,
    input  logic [15:0]      in_x,
    output logic             in_ready,
    output logic             valid_out,
    output logic [15:0]      log2_sum,
    output logic [CNT_W-1:0] count_out,
    output logic             err_zero
);

    localparam int EXP_W = $clog2(ACC_W);
    localparam int FRAC  = 12;
    localparam logic signed [EXP_W+1:0] E_MIN  = -8;
    localparam logic signed [EXP_W+1:0] E_MAX  = 7;
    localparam logic signed [EXP_W+1:0] E_BIAS = FRAC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_NORM,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [EXP_W-1:0]   exp_reg, exp_next;
    logic [15:0]        res_reg, res_next;
    logic               res_err_reg, res_err_next;
    logic               valid_out_reg, valid_out_next;
    logic [15:0]        log2_sum_reg, log2_sum_next;
    logic [CNT_W-1:0]   count_out_reg, count_out_next;
    logic               err_zero_reg, err_zero_next;

    logic [12:0]        clamped;
    logic               beat;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               at_max;
    logic signed [EXP_W+1:0] e_val;
    logic [11:0]        mant;
    logic [15:0]        norm_result;

    assign in_ready = en && (state_reg == ST_IDLE || state_reg == ST_ACC);
    assign beat     = valid_in && in_ready;

    // Negative inputs contribute nothing; anything above 1.0 is capped at 1.0.
    always_comb begin
        clamped = in_x[12:0];
        if (in_x[15]) begin
            clamped = 13'h0000;
        end else if (in_x > 16'h1000) begin
            clamped = 13'h1000;
        end
    end

    assign acc_sum = acc_reg + ACC_W'(clamped);
    assign cnt_inc = cnt_reg + CNT_W'(1);
    assign at_max  = (cnt_inc == CNT_W'(MAX_LEN));

    // Once acc is normalised its MSB is the implicit 1; the next 12 bits are the mantissa.
    assign e_val = $signed({2'b00, exp_reg}) - E_BIAS;
    assign mant  = acc_reg[ACC_W-2 -: 12];

    always_comb begin
        norm_result = {e_val[3:0], mant};
        if (e_val < E_MIN) begin
            norm_result = 16'h8000;
        end else if (e_val > E_MAX) begin
            norm_result = 16'h7FFF;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        exp_next       = exp_reg;
        res_next       = res_reg;
        res_err_next   = res_err_reg;
        valid_out_next = (state_reg == ST_DONE);
        log2_sum_next  = log2_sum_reg;
        count_out_next = count_out_reg;
        err_zero_next  = err_zero_reg;

        case (state_reg)
            ST_IDLE: begin
                if (beat) begin
                    acc_next = ACC_W'(clamped);
                    cnt_next = CNT_W'(1);
                    if (last_in) begin
                        state_next = ST_NORM;
                        exp_next   = EXP_W'(ACC_W - 1);
                    end else begin
                        state_next = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_next = acc_sum;
                    cnt_next = cnt_inc;
                    // Reaching MAX_LEN closes the vector even without last_in.
                    if (last_in || at_max) begin
                        state_next = ST_NORM;
                        exp_next   = EXP_W'(ACC_W - 1);
                    end
                end
            end
            ST_NORM: begin
                if (acc_reg == '0) begin
                    res_next     = 16'h8000;
                    res_err_next = 1'b1;
                    state_next   = ST_DONE;
                end else if (!acc_reg[ACC_W-1]) begin
                    acc_next = acc_reg << 1;
                    exp_next = exp_reg - EXP_W'(1);
                end else begin
                    res_next     = norm_result;
                    res_err_next = 1'b0;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                log2_sum_next  = res_reg;
                count_out_next = cnt_reg;
                err_zero_next  = res_err_reg;
                acc_next       = '0;
                cnt_next       = '0;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            exp_reg       <= '0;
            res_reg       <= '0;
            res_err_reg   <= 1'b0;
            valid_out_reg <= 1'b0;
            log2_sum_reg  <= '0;
            count_out_reg <= '0;
            err_zero_reg  <= 1'b0;
        end else if (en) begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            exp_reg       <= exp_next;
            res_reg       <= res_next;
            res_err_reg   <= res_err_next;
            valid_out_reg <= valid_out_next;
            log2_sum_reg  <= log2_sum_next;
            count_out_reg <= count_out_next;
            err_zero_reg  <= err_zero_next;
        end
    end

    assign valid_out = valid_out_reg;
    assign log2_sum  = log2_sum_reg;
    assign count_out = count_out_reg;
    assign err_zero  = err_zero_reg;

endmodule

// File: tb/tb_log2_sum_acc.sv
// Self-checking bench for log2_sum_acc: directed scenarios plus randomized vectors
// compared against an arithmetic model of the clamped sum and its Mitchell log2.
module tb_log2_sum_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        valid_in = 1'b0;
    logic        last_in = 1'b0;
    logic [15:0] in_x = 16'h0000;
    logic        in_ready;
    logic        valid_out;
    logic [15:0] log2_sum;
    logic [6:0]  count_out;
    logic        err_zero;

    int checks = 0;
    int errors = 0;
    logic [15:0] vec [0:127];

    log2_sum_acc dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .in_x      (in_x),
        .in_ready  (in_ready),
        .valid_out (valid_out),
        .log2_sum  (log2_sum),
        .count_out (count_out),
        .err_zero  (err_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: clamp, sum, then log2(sum) ~= floor(log2) + linear fraction of the remainder.
    task automatic model(input int n, output logic [15:0] r, output logic ez, output int lat);
        int unsigned sum;
        int          p;
        int          e;
        longint      frac;
        logic [15:0] v;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            v = vec[i];
            if (v[15]) sum += 0;
            else if (v > 16'h1000) sum += 32'h1000;
            else sum += 32'(v);
        end
        if (sum == 0) begin
            r = 16'h8000; ez = 1'b1; lat = 2;
        end else begin
            p = 0;
            for (int b = 0; b < 32; b++) if (sum[b]) p = b;
            e    = p - 12;
            lat  = (18 - p) + 2;
            frac = (longint'(sum - (32'd1 << p)) * 4096) >> p;
            if (e < -8) r = 16'h8000;
            else if (e > 7) r = 16'h7FFF;
            else r = 16'(e * 4096 + int'(frac));
            ez = 1'b0;
        end
    endtask

    task automatic run_vec(input int n, input bit use_last, input bit extra_beat,
                           input bit gaps, input bit hold_en, input string tag);
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        model(n, exp_res, exp_err, exp_lat);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                valid_in = 1'b0;
                last_in  = 1'($urandom_range(0, 1));
                in_x     = 16'($urandom);
            end
            @(negedge clk);
            if (i == 0) check({tag, "_ready"}, 32'(in_ready), 32'd1);
            valid_in = 1'b1;
            in_x     = vec[i];
            last_in  = use_last && (i == n - 1);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        if (extra_beat) begin
            valid_in = 1'b1; in_x = 16'h1000; last_in = 1'b1;
        end else begin
            valid_in = 1'b0; last_in = 1'b0;
        end
        lat = 0;
        for (int j = 1; j <= 60; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) begin
                valid_in = 1'b0; last_in = 1'b0;
            end
            if (valid_out) begin
                lat = j;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_log2"}, 32'(log2_sum), 32'(exp_res));
        check({tag, "_cnt"}, 32'(count_out), 32'(n));
        check({tag, "_err"}, 32'(err_zero), 32'(exp_err));
        if (hold_en) begin
            en = 1'b0;
            repeat (3) @(negedge clk);
            check({tag, "_hold_vo"}, 32'(valid_out), 32'd1);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            en = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        check({tag, "_pulse"}, 32'(valid_out), 32'd0);
        $display("vec %s n=%0d log2_sum=%04h count=%0d err_zero=%0b latency=%0d",
                 tag, n, log2_sum, count_out, err_zero, lat);
    endtask

    initial begin
        int n;
        int kind;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vo", 32'(valid_out), 32'd0);
        check("rst_log2", 32'(log2_sum), 32'd0);
        check("rst_cnt", 32'(count_out), 32'd0);
        check("rst_err", 32'(err_zero), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;

        // last_in without valid_in must not start or close anything
        @(negedge clk);
        last_in = 1'b1; in_x = 16'h1000;
        repeat (3) @(negedge clk);
        check("stray_last", 32'(valid_out), 32'd0);
        last_in = 1'b0;

        vec[0] = 16'h1000;
        run_vec(1, 1, 0, 0, 0, "s1");
        for (int i = 0; i < 4; i++) vec[i] = 16'h1000;
        run_vec(4, 1, 0, 0, 0, "s2");
        vec[0] = 16'h1000; vec[1] = 16'h0800;
        run_vec(2, 1, 0, 0, 0, "s3");
        vec[0] = 16'hE316; vec[1] = 16'h2400;
        run_vec(2, 1, 0, 0, 0, "s4");
        for (int i = 0; i < 3; i++) vec[i] = 16'h0000;
        run_vec(3, 1, 0, 0, 0, "s5");
        for (int i = 0; i < 64; i++) vec[i] = 16'h1000;
        run_vec(64, 0, 1, 0, 0, "s6");

        // Reset while normalising a tiny sum: the vector is discarded
        @(negedge clk);
        valid_in = 1'b1; in_x = 16'h0001; last_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0; last_in = 1'b0;
        repeat (3) @(negedge clk);
        check("norm_busy", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_vo", 32'(valid_out), 32'd0);
        check("mid_rst_log2", 32'(log2_sum), 32'd0);
        check("mid_rst_cnt", 32'(count_out), 32'd0);
        check("mid_rst_err", 32'(err_zero), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        vec[0] = 16'h1000;
        run_vec(1, 1, 0, 0, 0, "s1_again");

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0: vec[i] = 16'($urandom);
                    1: vec[i] = 16'($urandom_range(0, 4096));
                    2: vec[i] = 16'($urandom_range(0, 15));
                    default: vec[i] = 16'h0000;
                endcase
            end
            run_vec(n, 1, 0, 1, (t == 5), $sformatf("rnd%0d", t));
        end
        for (int i = 0; i < 64; i++) vec[i] = 16'($urandom_range(0, 255));
        run_vec(64, 0, 0, 1, 0, "rnd_full");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
